// File: rtl/df_tap_accumulator.sv
// Sequential tap accumulator: steps tap_idx through all taps, sums the upstream
// products, and emits one scaled 8-bit sample. Define DF_ACC_SATURATE_EN to clamp instead of wrap.
module df_tap_accumulator #(
    parameter int TAPS      = 8,
    parameter int ACC_W     = 11,
    parameter int OUT_SHIFT = 3,
    parameter int IDX_W     = (TAPS > 2) ? $clog2(TAPS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       prod,
    output logic [IDX_W-1:0] tap_idx,
    output logic             busy,
    output logic [7:0]       result,
    output logic             result_valid,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] sum_s;
    logic [IDX_W-1:0] tap_idx_r;
    logic [IDX_W-1:0] tap_idx_s;
    logic             busy_r;
    logic             busy_s;
    logic [7:0]       result_r;
    logic [7:0]       result_s;
    logic             valid_r;
    logic             valid_s;
    logic             overrun_r;
    logic             overrun_s;
    logic             last_tap_s;

    // Scale the full sum down to the 8-bit output, clamping or wrapping by build.
    function automatic logic [7:0] scale_f(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] s;
        s = sum >> OUT_SHIFT;
`ifdef DF_ACC_SATURATE_EN
        if (s > ACC_W'(255)) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
`else
        return s[7:0];
`endif
    endfunction

    assign sum_s      = acc_r + {{(ACC_W-8){1'b0}}, prod};
    assign last_tap_s = (tap_idx_r == IDX_W'(TAPS - 1));

    // State register plus all registered outputs and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            acc_r     <= '0;
            tap_idx_r <= '0;
            busy_r    <= 1'b0;
            result_r  <= 8'h00;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            tap_idx_r <= tap_idx_s;
            busy_r    <= busy_s;
            result_r  <= result_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
        end
    end

    // Next-state decode; a start in DONE restarts without a dead cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (last_tap_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ACCUM;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of outputs and datapath; outputs follow the upcoming state.
    always_comb begin
        acc_s     = acc_r;
        tap_idx_s = '0;
        result_s  = result_r;
        overrun_s = overrun_r;
        busy_s    = (state_s == ACCUM);
        valid_s   = (state_s == DONE);
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_s = '0;
                end else begin
                    acc_s = acc_r;
                end
            end
            ACCUM: begin
                acc_s = sum_s;
                if (last_tap_s) begin
                    tap_idx_s = '0;
                    result_s  = scale_f(sum_s);
                end else begin
                    tap_idx_s = tap_idx_r + IDX_W'(1);
                end
                // A strobe here is dropped but remembered until reset.
                if (start) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
            end
            DONE: begin
                if (start) begin
                    acc_s = '0;
                end else begin
                    acc_s = acc_r;
                end
            end
            default: begin
                acc_s = '0;
            end
        endcase
    end

    assign tap_idx      = tap_idx_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = valid_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_df_tap_accumulator.sv
// Bench for df_tap_accumulator: default instance plus an OUT_SHIFT=0 instance for saturate/wrap.
module tb_df_tap_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] prod;
    logic [7:0] prod2;
    logic [2:0] tap_idx;
    logic [2:0] tap_idx2;
    logic       busy;
    logic       busy2;
    logic [7:0] result;
    logic [7:0] result2;
    logic       result_valid;
    logic       result_valid2;
    logic       overrun;
    logic       overrun2;

    logic       mode;
    logic [7:0] pval;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       mode;
        logic [7:0] pval;
        logic [7:0] exp1;
    } vec_t;

    typedef struct {
        logic [7:0] exp1;
        logic [7:0] exp2;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[6];

    df_tap_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prod(prod),
        .tap_idx(tap_idx), .busy(busy), .result(result),
        .result_valid(result_valid), .overrun(overrun)
    );

    df_tap_accumulator #(.OUT_SHIFT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .prod(prod2),
        .tap_idx(tap_idx2), .busy(busy2), .result(result2),
        .result_valid(result_valid2), .overrun(overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream multiplier model: constant product or tap_idx*16.
    always_comb begin
        if (mode) prod = {1'b0, tap_idx, 4'h0};
        else      prod = pval;
        prod2 = pval;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected output of the OUT_SHIFT=0 instance for a constant product over 8 taps.
    function automatic logic [7:0] model2(input logic [7:0] p);
        int s;
        s = int'(p) * 8;
`ifdef DF_ACC_SATURATE_EN
        if (s > 255) return 8'hFF;
`endif
        return s[7:0];
    endfunction

    // Scoreboard monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("result", int'(result), int'(e.exp1));
                    chk("result_sat_wrap", int'(result2), int'(e.exp2));
                    chk("valid2_aligned", int'(result_valid2), 1);
                end
            end else if (result_valid2) begin
                chk("valid2_aligned", 1, 0);
            end
        end
    end

    task automatic start_sample(input logic m, input logic [7:0] p, input logic [7:0] e1);
        sb_t e;
        mode  = m;
        pval  = p;
        start = 1'b1;
        e.exp1 = e1;
        e.exp2 = model2(p);
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for result_valid, counting cycles since the start edge.
    task automatic wait_valid(input int c0, output int cnt, output int bcnt, output int tap_ok);
        cnt    = c0;
        bcnt   = 0;
        tap_ok = 1;
        while (!result_valid && cnt < 40) begin
            if (busy) bcnt++;
            if (int'(tap_idx) != cnt - 1) tap_ok = 0;
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        int cnt, bcnt, tap_ok, n;
        sb_t dropped;

        vecs[0] = '{1'b0, 8'hFF, 8'hFF};
        vecs[1] = '{1'b1, 8'h40, 8'h38};
        vecs[2] = '{1'b0, 8'h10, 8'h10};
        vecs[3] = '{1'b0, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 8'h07, 8'h07};
        vecs[5] = '{1'b0, 8'h01, 8'h01};

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        pval  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tap_idx", int'(tap_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start_sample(vecs[i].mode, vecs[i].pval, vecs[i].exp1);
            wait_valid(1, cnt, bcnt, tap_ok);
            chk("latency", cnt, 9);
            chk("busy_cycles", bcnt, 8);
            chk("tap_sequence", tap_ok, 1);
            chk("tap_idx_done", int'(tap_idx), 0);
            chk("busy_done", int'(busy), 0);
            @(negedge clk);
            chk("valid_one_cycle", int'(result_valid), 0);
            @(negedge clk);
        end
        chk("overrun_clear", int'(overrun), 0);

        // Second strobe three cycles into ACCUM is dropped and flagged.
        start_sample(1'b0, 8'h22, 8'h22);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(4, cnt, bcnt, tap_ok);
        chk("overrun_latency", cnt, 9);
        chk("overrun_tap_sequence", tap_ok, 1);
        repeat (2) @(negedge clk);
        chk("no_second_sequence", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("overrun_set", int'(overrun), 1);
        start_sample(vecs[4].mode, vecs[4].pval, vecs[4].exp1);
        wait_valid(1, cnt, bcnt, tap_ok);
        chk("overrun_after_latency", cnt, 9);
        @(negedge clk);
        chk("overrun_sticky", int'(overrun), 1);
        @(negedge clk);

        // Back-to-back: restart during the DONE cycle.
        start_sample(1'b0, 8'h10, 8'h10);
        wait_valid(1, cnt, bcnt, tap_ok);
        chk("b2b_first_latency", cnt, 9);
        start_sample(1'b0, 8'h20, 8'h20);
        wait_valid(1, cnt, bcnt, tap_ok);
        chk("b2b_gap", cnt, 9);
        chk("b2b_busy_cycles", bcnt, 8);
        repeat (2) @(negedge clk);

        // Reset mid-sequence at tap_idx 4.
        start_sample(1'b0, 8'h33, 8'h33);
        n = 0;
        while (tap_idx != 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_tap4", int'(tap_idx), 4);
        rst_n = 1'b0;
        #1;
        chk("abort_tap_idx", int'(tap_idx), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_valid", int'(result_valid), 0);
        chk("abort_overrun", int'(overrun), 0);
        dropped = sbq.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        start_sample(1'b1, 8'h40, 8'h38);
        wait_valid(1, cnt, bcnt, tap_ok);
        chk("post_reset_latency", cnt, 9);
        chk("post_reset_tap_sequence", tap_ok, 1);
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
